// File: rtl/vmem_pkg.sv
// Shared constants and types for the video RAM arbiter.
// The display fetcher uses the same VMEM_END for its address wrap.
package vmem_pkg;

  localparam int ADDR_W         = 20;
  localparam int DATA_W         = 8;
  localparam int VMEM_END       = 153599;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  // Identifies who owns the read that is in flight and whether it skipped the RAM.
  typedef struct packed {
    tag_t tag;
    logic oor;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_IDLE = '{tag: TAG_NONE, oor: 1'b0};

  function automatic logic addr_oor(input logic [ADDR_W-1:0] addr);
    return addr > ADDR_W'(VMEM_END);
  endfunction

endpackage

// File: rtl/vmem_if.sv
// Bundle of the display, CPU and RAM-side signals around the arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface vmem_if;
  import vmem_pkg::*;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output disp_ack, disp_rvalid, disp_rdata,
    output cpu_ack, cpu_rvalid, cpu_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_req, disp_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  disp_ack, disp_rvalid, disp_rdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vmem_rd_pipe.sv
// Two-deep delay line for read ownership tags; lines the tag up with the
// RAM data that returns two cycles after the request was accepted.
module vmem_rd_pipe
  import vmem_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage1;
  rd_tag_t stage2;

  // NOTE: clearing the tags is what discards reads in flight, so no rvalid
  // can appear after reset release even though RAM data is never reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage1 <= RD_TAG_IDLE;
      stage2 <= RD_TAG_IDLE;
    end else begin
      // NOTE: non-blocking so stage2 takes the old stage1, forming a real shift.
      stage1 <= tag_in;
      stage2 <= stage1;
    end
  end

  assign tag_out = stage2;

endmodule

// File: rtl/vmem_arbiter.sv
// Display/CPU arbiter for the single-port video RAM: display priority,
// bounded CPU starvation, registered RAM port, fixed 3-cycle read latency.
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic   clk,
  input logic   rst,
  vmem_if.slave bus
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_DISP,
    GRANT_CPU
  } grant_t;

  grant_t            grant;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_nxt;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [DATA_W-1:0] win_wdata;
  logic              win_oor;
  rd_tag_t           issue_tag;
  rd_tag_t           return_tag;

  // Acks are gated by reset so every output reads 0 while rst is low.
  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = GRANT_NONE;
    if (rst) begin
      if (bus.disp_req && bus.cpu_req) begin
        grant = (starve_cnt == CNT_MAX) ? GRANT_CPU : GRANT_DISP;
      end else if (bus.disp_req) begin
        grant = GRANT_DISP;
      end else if (bus.cpu_req) begin
        grant = GRANT_CPU;
      end
    end
  end

  assign bus.disp_ack = (grant == GRANT_DISP);
  assign bus.cpu_ack  = (grant == GRANT_CPU);

  always_comb begin
    starve_nxt = '0;
    if (bus.cpu_req && (grant != GRANT_CPU)) begin
      starve_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  always_comb begin
    win_addr  = bus.disp_addr;
    win_we    = 1'b0;
    win_wdata = bus.cpu_wdata;
    issue_tag = RD_TAG_IDLE;
    if (grant == GRANT_CPU) begin
      win_addr = bus.cpu_addr;
      win_we   = bus.cpu_we;
    end
    win_oor = addr_oor(win_addr);
    // Writes carry no tag: only reads produce an rvalid.
    if (grant == GRANT_DISP) begin
      issue_tag = '{tag: TAG_DISP, oor: win_oor};
    end else if ((grant == GRANT_CPU) && !bus.cpu_we) begin
      issue_tag = '{tag: TAG_CPU, oor: win_oor};
    end
  end

  // Out-of-range accesses never reach the RAM: address held, write suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      starve_cnt    <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      starve_cnt <= starve_nxt;
      if ((grant != GRANT_NONE) && !win_oor) begin
        bus.mem_addr <= win_addr;
        bus.mem_we   <= win_we;
        if (win_we) begin
          bus.mem_wdata <= win_wdata;
        end
      end
    end
  end

  vmem_rd_pipe u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (issue_tag),
    .tag_out (return_tag)
  );

  // Registering mem_rdata here gives the third cycle of read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.disp_rvalid <= 1'b0;
      bus.disp_rdata  <= '0;
      bus.cpu_rvalid  <= 1'b0;
      bus.cpu_rdata   <= '0;
    end else begin
      bus.disp_rvalid <= (return_tag.tag == TAG_DISP);
      bus.cpu_rvalid  <= (return_tag.tag == TAG_CPU);
      if (return_tag.tag == TAG_DISP) begin
        bus.disp_rdata <= return_tag.oor ? '0 : bus.mem_rdata;
      end
      if (return_tag.tag == TAG_CPU) begin
        bus.cpu_rdata <= return_tag.oor ? '0 : bus.mem_rdata;
      end
    end
  end

endmodule
